seg_display_sched: RTL and testbench
====================================

// Module: seg_display_sched
// PURPOSE
//  Scheduler in front of the 4-digit seven-segment scanner. Generates the digit-scan
//  strobe, shares the display between a measurement stream and a priority message
//  source, and swaps displayed content only on frame boundaries (no tearing).
//  Sits between the measurement/UI logic and the seven-segment scanner.
// PARAMETERS
//  DIV          1000  clk cycles per digit slot (>=2); frame = 4*DIV cycles
//  HOLD_FRAMES  250   frames a message stays on display (>=1)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  meas_valid  in   1   measurement digits valid
//  meas_bcd    in   16  measurement BCD, digit0 = [3:0] ... digit3 = [15:12]
//  meas_ready  out  1   measurement accept (always 1 outside reset)
//  msg_valid   in   1   message digits valid
//  msg_bcd     in   16  message BCD/hex codes, same packing
//  msg_ready   out  1   message accept; low while a message is pending
//  digit_tick  out  1   one-cycle strobe: scanner advances one digit
//  frame_start out  1   one-cycle strobe coincident with digit_tick when index wraps 3->0
//  disp_bcd    out  16  digits for the scanner, registered
//  blank       out  4   per-digit blank (1 = segments off)
//  src_msg     out  1   1 while a message is displayed
// BEHAVIOUR
//  Reset: prescaler=0, digit index=0, state IDLE, disp_bcd=16'h0000, blank=4'hF,
//   digit_tick=0, frame_start=0, src_msg=0, meas_ready=0, both pending slots empty.
//  Prescaler counts 0..DIV-1, wraps; digit_tick=1 in cycle where count==DIV-1.
//  Digit index (2 bit) increments on digit_tick, wraps 3->0; frame boundary (FB) =
//   digit_tick && index==3; frame_start asserted in that cycle.
//  Handshakes: transfer when valid && ready, sampled at clk edge.
//   meas: 1-entry pending slot, newest accepted value overwrites (sample-latest).
//   msg: 1-entry pending slot, msg_ready = !msg_pend; no overwrite, no drop.
//  States: IDLE (nothing shown), MEAS, MSG. All transitions and disp_bcd/blank/src_msg
//   updates happen only on FB edges; outputs visible the cycle after FB.
//   any state, msg_pend at FB -> load msg, MSG, hold=HOLD_FRAMES, clear msg_pend.
//   MSG, no msg_pend at FB: hold-=1; hold reaches 0 -> MEAS (shows last_meas) if a
//    measurement was ever loaded, else IDLE.
//   IDLE/MEAS, meas_pend at FB -> last_meas<=pending, disp_bcd<=pending, MEAS, clear.
//   MSG, meas_pend at FB -> last_meas<=pending (not displayed), clear meas_pend.
//  Message preempts: new message at FB during MSG restarts hold at HOLD_FRAMES.
//  Accept and consume in same cycle: consumed value is the old one; new value
//   remains pending (msg_ready stays low for that slot).
//  Message shown for exactly HOLD_FRAMES frames when no new message arrives.
//  Latency: value accepted at edge t displayed after first FB strictly after t.
//  IDLE: blank=4'hF. MSG: blank=4'h0. MEAS: blank per CONFIGURATION.
//  hold counter width $clog2(HOLD_FRAMES+1); prescaler width $clog2(DIV).
//  rst mid-frame: all state cleared next edge, pending data discarded.
// CONFIGURATION
//  SEG_LZB_EN defined: leading-zero blanking in MEAS; digits 3..1 blanked while they
//   and all higher digits equal 4'h0; digit0 never blanked (0000 -> blank=4'b1110).
//  SEG_LZB_EN undefined: blank=4'h0 in MEAS; blanking logic absent.
// TESTING (DIV=4, HOLD_FRAMES=2, frame=16 cycles)
//  Reset release -> digit_tick every 4th cycle, frame_start every 16th, blank=4'hF, IDLE.
//  meas 16'h1234 mid-frame -> disp_bcd=16'h1234, blank=0 only after next FB, src_msg=0.
//  meas 16'h0042 with SEG_LZB_EN -> blank=4'b1100; without macro -> blank=4'b0000.
//  msg 16'hDEAD during MEAS -> shown 2 frames, src_msg=1, then back to last meas.
//  Two msgs back-to-back -> msg_ready low after first until next FB; second restarts hold.
//  meas 16'h0001 then 16'h0002 in same frame -> only 16'h0002 displayed; rst mid-frame
//   -> next cycle blank=4'hF, disp_bcd=0, pending msg lost, msg_ready=1 after reset.

Source files
------------

// File: rtl/seg_display_sched_if.sv
// -----------------------------------------------------------------------------
// seg_display_sched_if
// Bundles the signals between the measurement/UI logic, the display scheduler
// and the seven-segment scanner.
//   meas_valid/meas_bcd/meas_ready : measurement stream (sample-latest)
//   msg_valid/msg_bcd/msg_ready    : priority message source (no drop)
//   digit_tick/frame_start         : scan strobes towards the scanner
//   disp_bcd/blank/src_msg         : registered display content
// Modports:
//   master : producer/scanner side (drives valid/data, observes the rest)
//   slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface seg_display_sched_if;
  logic        meas_valid;
  logic [15:0] meas_bcd;
  logic        meas_ready;
  logic        msg_valid;
  logic [15:0] msg_bcd;
  logic        msg_ready;
  logic        digit_tick;
  logic        frame_start;
  logic [15:0] disp_bcd;
  logic [3:0]  blank;
  logic        src_msg;

  modport master (
    output meas_valid, meas_bcd, msg_valid, msg_bcd,
    input  meas_ready, msg_ready, digit_tick, frame_start,
           disp_bcd, blank, src_msg
  );

  modport slave (
    input  meas_valid, meas_bcd, msg_valid, msg_bcd,
    output meas_ready, msg_ready, digit_tick, frame_start,
           disp_bcd, blank, src_msg
  );
endinterface

// File: rtl/seg_display_sched.sv
// -----------------------------------------------------------------------------
// seg_display_sched
// Scheduler in front of a 4-digit seven-segment scanner. Generates the digit
// scan strobe, shares the display between a measurement stream and a priority
// message source, and swaps the displayed content only on frame boundaries so
// the scanner never shows a mix of old and new digits.
//
// Parameters:
//   DIV         : clk cycles per digit slot (>=2); one frame = 4*DIV cycles
//   HOLD_FRAMES : frames a message stays on display (>=1)
// Ports:
//   i_clk : system clock
//   i_rst : synchronous, active-high reset
//   bus   : seg_display_sched_if.slave (handshakes, strobes, display outputs)
// Optional feature:
//   SEG_LZB_EN : when defined, leading zeros of a displayed measurement are
//                blanked (digit0 is never blanked). When undefined, all four
//                digits are lit while a measurement is shown.
// -----------------------------------------------------------------------------
module seg_display_sched #(
  parameter int DIV         = 1000,
  parameter int HOLD_FRAMES = 250
) (
  input  logic                i_clk,
  input  logic                i_rst,
  seg_display_sched_if.slave  bus
);

  localparam int PW = $clog2(DIV);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_MSG  = 2'd2
  } state_t;

  // Scan timing
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic          w_tick;
  logic          w_fb;

  // Handshake slots
  logic          r_rdy;
  logic          r_meas_pend;
  logic [15:0]   r_meas_data;
  logic          r_msg_pend;
  logic [15:0]   r_msg_data;
  logic          w_meas_acc;
  logic          w_msg_acc;
  logic          w_meas_take;
  logic          w_msg_take;

  // Display state
  state_t        r_state;
  state_t        w_state_next;
  logic [15:0]   r_disp;
  logic [15:0]   w_disp_next;
  logic [3:0]    r_blank;
  logic [3:0]    w_blank_next;
  logic          r_src;
  logic          w_src_next;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_next;
  logic [15:0]   r_last_meas;
  logic [15:0]   w_last_next;
  logic          r_have_meas;
  logic          w_have_next;

  // Measurement that would be shown if a MEAS display is entered at this FB:
  // a pending sample is always newer than the remembered one.
  logic [15:0]   w_meas_show;
  logic [3:0]    w_meas_blank;

  assign w_tick = (r_presc == PRESC_MAX);
  assign w_fb   = w_tick && (r_idx == 2'd3);

  assign w_meas_acc = bus.meas_valid && r_rdy;
  assign w_msg_acc  = bus.msg_valid && r_rdy && !r_msg_pend;

  assign w_meas_show = r_meas_pend ? r_meas_data : r_last_meas;

`ifdef SEG_LZB_EN
  // A digit is blanked when it and every higher digit are zero.
  logic [3:1] w_digit_zero;
  genvar gi;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_lzb
      assign w_digit_zero[gi] = (w_meas_show[gi*4 +: 4] == 4'h0);
      assign w_meas_blank[gi] = &w_digit_zero[3:gi];
    end
  endgenerate
  assign w_meas_blank[0] = 1'b0;
`else
  assign w_meas_blank = 4'h0;
`endif

  // ---------------------------------------------------------------------------
  // Prescaler and digit index
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending slots. A consume and an accept on the same edge leave the new
  // value pending; the consumer already latched the old one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdy       <= 1'b0;
      r_meas_pend <= 1'b0;
      r_meas_data <= 16'h0000;
      r_msg_pend  <= 1'b0;
      r_msg_data  <= 16'h0000;
    end else begin
      r_rdy <= 1'b1;
      if (w_meas_take) begin
        r_meas_pend <= 1'b0;
      end
      if (w_meas_acc) begin
        r_meas_pend <= 1'b1;
        r_meas_data <= bus.meas_bcd;
      end
      if (w_msg_take) begin
        r_msg_pend <= 1'b0;
      end
      if (w_msg_acc) begin
        r_msg_pend <= 1'b1;
        r_msg_data <= bus.msg_bcd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_disp      <= 16'h0000;
      r_blank     <= 4'hF;
      r_src       <= 1'b0;
      r_hold      <= '0;
      r_last_meas <= 16'h0000;
      r_have_meas <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_disp      <= w_disp_next;
      r_blank     <= w_blank_next;
      r_src       <= w_src_next;
      r_hold      <= w_hold_next;
      r_last_meas <= w_last_next;
      r_have_meas <= w_have_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Display FSM: next state. Everything changes only on a frame boundary.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_disp_next  = r_disp;
    w_blank_next = r_blank;
    w_src_next   = r_src;
    w_hold_next  = r_hold;
    w_last_next  = r_last_meas;
    w_have_next  = r_have_meas;
    w_meas_take  = 1'b0;
    w_msg_take   = 1'b0;

    if (w_fb) begin
      // A pending measurement is always absorbed into last_meas, even when a
      // message is (or stays) on display, so the return path shows the newest.
      if (r_meas_pend) begin
        w_last_next = r_meas_data;
        w_have_next = 1'b1;
        w_meas_take = 1'b1;
      end

      if (r_msg_pend) begin
        // New message preempts anything, including a running message.
        w_state_next = ST_MSG;
        w_disp_next  = r_msg_data;
        w_blank_next = 4'h0;
        w_src_next   = 1'b1;
        w_hold_next  = HOLD_INIT;
        w_msg_take   = 1'b1;
      end else begin
        case (r_state)
          ST_MSG: begin
            if (r_hold <= HOLD_ONE) begin
              w_hold_next = '0;
              w_src_next  = 1'b0;
              if (w_have_next) begin
                w_state_next = ST_MEAS;
                w_disp_next  = w_meas_show;
                w_blank_next = w_meas_blank;
              end else begin
                w_state_next = ST_IDLE;
                w_disp_next  = 16'h0000;
                w_blank_next = 4'hF;
              end
            end else begin
              w_hold_next = r_hold - HOLD_ONE;
            end
          end
          default: begin
            if (r_meas_pend) begin
              w_state_next = ST_MEAS;
              w_disp_next  = w_meas_show;
              w_blank_next = w_meas_blank;
              w_src_next   = 1'b0;
            end
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.meas_ready  = r_rdy;
  assign bus.msg_ready   = r_rdy && !r_msg_pend;
  assign bus.digit_tick  = w_tick;
  assign bus.frame_start = w_fb;
  assign bus.disp_bcd    = r_disp;
  assign bus.blank       = r_blank;
  assign bus.src_msg     = r_src;

endmodule

// File: tb/tb_seg_display_sched.sv
// -----------------------------------------------------------------------------
// tb_seg_display_sched
// Self-checking bench for seg_display_sched with DIV=4, HOLD_FRAMES=2.
// A frame-level reference model tracks the expected outputs every cycle; a
// table of frame-by-frame scenarios and a few hand sequences add constant
// expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_seg_display_sched;
  localparam int DIV   = 4;
  localparam int HOLD  = 2;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_display_sched_if bus();

  seg_display_sched #(.DIV(DIV), .HOLD_FRAMES(HOLD)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected MEAS blanking: digit k (k>=1) is dark when the value shifted
  // down by k digits is zero.
  function automatic logic [3:0] exp_meas_blank(input logic [15:0] v);
    logic [3:0] b;
    b = 4'h0;
`ifdef SEG_LZB_EN
    for (int k = 1; k < 4; k++) begin
      if ((v >> (4 * k)) == 16'h0) b[k] = 1'b1;
    end
`endif
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: cycle count since reset, frame numbers and a deadline.
  // ---------------------------------------------------------------------------
  int          m_cyc;
  bit          m_rdy, m_meas_pend, m_msg_pend, m_have, m_show_msg, m_src;
  logic [15:0] m_meas_d, m_msg_d, m_last, m_disp;
  logic [3:0]  m_blank;
  int          m_until;

  always @(posedge clk) begin
    bit acc_meas, acc_msg;
    int fnum;
    if (rst) begin
      m_cyc = 0; m_rdy = 0; m_meas_pend = 0; m_msg_pend = 0; m_have = 0;
      m_show_msg = 0; m_src = 0; m_disp = 16'h0; m_blank = 4'hF; m_until = 0;
      m_meas_d = 16'h0; m_msg_d = 16'h0; m_last = 16'h0;
    end else begin
      acc_meas = bus.meas_valid && m_rdy;
      acc_msg  = bus.msg_valid && m_rdy && !m_msg_pend;
      if ((m_cyc % FRAME) == FRAME - 1) begin
        fnum = (m_cyc + 1) / FRAME;
        if (m_meas_pend) begin m_last = m_meas_d; m_have = 1; end
        if (m_msg_pend) begin
          m_show_msg = 1; m_until = fnum + HOLD;
          m_disp = m_msg_d; m_blank = 4'h0; m_src = 1;
        end else if (m_show_msg) begin
          if (fnum == m_until) begin
            m_show_msg = 0; m_src = 0;
            if (m_have) begin m_disp = m_last; m_blank = exp_meas_blank(m_last); end
            else begin m_disp = 16'h0; m_blank = 4'hF; end
          end
        end else if (m_meas_pend) begin
          m_disp = m_last; m_blank = exp_meas_blank(m_last); m_src = 0;
        end
        m_meas_pend = 0;
        m_msg_pend  = 0;
      end
      if (acc_meas) begin m_meas_pend = 1; m_meas_d = bus.meas_bcd; end
      if (acc_msg)  begin m_msg_pend  = 1; m_msg_d  = bus.msg_bcd;  end
      m_rdy = 1;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_disp",   {16'h0, bus.disp_bcd},  {16'h0, m_disp});
      check("mdl_blank",  {28'h0, bus.blank},     {28'h0, m_blank});
      check("mdl_src",    {31'h0, bus.src_msg},   {31'h0, m_src});
      check("mdl_tick",   {31'h0, bus.digit_tick},  {31'h0, (m_cyc % DIV) == DIV - 1});
      check("mdl_fstart", {31'h0, bus.frame_start}, {31'h0, (m_cyc % FRAME) == FRAME - 1});
      check("mdl_mready", {31'h0, bus.meas_ready}, {31'h0, m_rdy});
      check("mdl_gready", {31'h0, bus.msg_ready},  {31'h0, m_rdy && !m_msg_pend});
    end
  end

  // Advance to the negedge just after the next frame boundary.
  task automatic wait_fb();
    bit got;
    got = 0;
    for (int k = 0; k < 3 * FRAME && !got; k++) begin
      @(negedge clk);
      if (bus.frame_start) got = 1;
    end
    if (!got) check("wait_fb_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic pulse_meas(input logic [15:0] v);
    bus.meas_valid = 1'b1; bus.meas_bcd = v;
    @(negedge clk);
    bus.meas_valid = 1'b0;
  endtask

  typedef struct {
    logic        meas_v;
    logic [15:0] meas;
    logic        msg_v;
    logic [15:0] msg;
    int          frames;
    logic [15:0] exp_disp;
    logic [3:0]  exp_blank_lzb;
    logic [3:0]  exp_blank_plain;
    logic        exp_src;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int ticks, fstarts, first_tick;
    logic [3:0] eb;

    bus.meas_valid = 0; bus.meas_bcd = 0; bus.msg_valid = 0; bus.msg_bcd = 0;

    //          mv  meas      gv  msg       fr disp      lzb      plain    src
    vecs[0] = '{1'b1, 16'h1234, 1'b0, 16'h0000, 1, 16'h1234, 4'b0000, 4'b0000, 1'b0};
    vecs[1] = '{1'b1, 16'h0042, 1'b0, 16'h0000, 1, 16'h0042, 4'b1100, 4'b0000, 1'b0};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'hDEAD, 1, 16'hDEAD, 4'b0000, 4'b0000, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1, 16'hDEAD, 4'b0000, 4'b0000, 1'b1};
    vecs[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1, 16'h0042, 4'b1100, 4'b0000, 1'b0};
    vecs[5] = '{1'b1, 16'h0007, 1'b1, 16'h0BEE, 1, 16'h0BEE, 4'b0000, 4'b0000, 1'b1};
    vecs[6] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 2, 16'h0007, 4'b1110, 4'b0000, 1'b0};
    vecs[7] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1, 16'h0000, 4'b1110, 4'b0000, 1'b0};
    vecs[8] = '{1'b1, 16'h9000, 1'b0, 16'h0000, 1, 16'h9000, 4'b0000, 4'b0000, 1'b0};
    vecs[9] = '{1'b1, 16'h0100, 1'b0, 16'h0000, 1, 16'h0100, 4'b1000, 4'b0000, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_blank",  {28'h0, bus.blank},      32'hF);
    check("rst_disp",   {16'h0, bus.disp_bcd},   32'h0);
    check("rst_src",    {31'h0, bus.src_msg},    32'h0);
    check("rst_mready", {31'h0, bus.meas_ready}, 32'h0);
    check("rst_tick",   {31'h0, bus.digit_tick}, 32'h0);

    // Scan strobes after release
    rst = 1'b0;
    ticks = 0; fstarts = 0; first_tick = -1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bus.digit_tick) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
      end
      if (bus.frame_start) fstarts++;
    end
    check("first_tick",  first_tick, 32'd2);
    check("tick_count",  ticks,      32'd8);
    check("fstart_count", fstarts,   32'd2);
    check("idle_blank",  {28'h0, bus.blank}, 32'hF);
    check("mready_up",   {31'h0, bus.meas_ready}, 32'h1);

    // Table-driven frame scenarios
    foreach (vecs[i]) begin
      repeat (5) @(negedge clk);
      bus.meas_valid = vecs[i].meas_v; bus.meas_bcd = vecs[i].meas;
      bus.msg_valid  = vecs[i].msg_v;  bus.msg_bcd  = vecs[i].msg;
      @(negedge clk);
      bus.meas_valid = 0; bus.msg_valid = 0;
      for (int f = 0; f < vecs[i].frames; f++) wait_fb();
`ifdef SEG_LZB_EN
      eb = vecs[i].exp_blank_lzb;
`else
      eb = vecs[i].exp_blank_plain;
`endif
      $display("vec%0d: disp=%h blank=%b src=%0d", i, bus.disp_bcd, bus.blank, bus.src_msg);
      check($sformatf("vec%0d_disp", i),  {16'h0, bus.disp_bcd}, {16'h0, vecs[i].exp_disp});
      check($sformatf("vec%0d_blank", i), {28'h0, bus.blank},    {28'h0, eb});
      check($sformatf("vec%0d_src", i),   {31'h0, bus.src_msg},  {31'h0, vecs[i].exp_src});
    end

    // Latency: nothing changes until the boundary edge itself
    repeat (3) @(negedge clk);
    pulse_meas(16'h1234);
    for (int k = 0; k < 3 * FRAME && !bus.frame_start; k++) @(negedge clk);
    check("lat_before", {16'h0, bus.disp_bcd}, 32'h0100);
    @(negedge clk);
    check("lat_after",  {16'h0, bus.disp_bcd}, 32'h1234);

    // Sample-latest within one frame
    repeat (2) @(negedge clk);
    pulse_meas(16'h0001);
    pulse_meas(16'h0002);
    wait_fb();
    check("latest_disp", {16'h0, bus.disp_bcd}, 32'h0002);

    // Back-to-back messages
    repeat (2) @(negedge clk);
    bus.msg_valid = 1'b1; bus.msg_bcd = 16'hAAAA;
    @(negedge clk);
    check("b2b_ready_low", {31'h0, bus.msg_ready}, 32'h0);
    bus.msg_bcd = 16'hBBBB;
    wait_fb();
    check("b2b_first",     {16'h0, bus.disp_bcd},  32'hAAAA);
    check("b2b_ready_up",  {31'h0, bus.msg_ready}, 32'h1);
    @(negedge clk);
    bus.msg_valid = 1'b0;
    check("b2b_ready_low2", {31'h0, bus.msg_ready}, 32'h0);
    wait_fb();
    check("b2b_second",    {16'h0, bus.disp_bcd}, 32'hBBBB);
    wait_fb();
    check("b2b_hold",      {16'h0, bus.disp_bcd}, 32'hBBBB);
    check("b2b_hold_src",  {31'h0, bus.src_msg},  32'h1);
    wait_fb();
    check("b2b_back",      {16'h0, bus.disp_bcd}, 32'h0002);
    check("b2b_back_src",  {31'h0, bus.src_msg},  32'h0);

    // Reset mid-frame with a message pending
    repeat (3) @(negedge clk);
    bus.msg_valid = 1'b1; bus.msg_bcd = 16'hCCCC;
    @(negedge clk);
    bus.msg_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mrst_blank", {28'h0, bus.blank},    32'hF);
    check("mrst_disp",  {16'h0, bus.disp_bcd}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_gready", {31'h0, bus.msg_ready}, 32'h1);
    wait_fb();
    check("mrst_lost_blank", {28'h0, bus.blank},   32'hF);
    check("mrst_lost_src",   {31'h0, bus.src_msg}, 32'h0);

    // Randomized run against the model
    for (int c = 0; c < 1500; c++) begin
      logic [15:0] mask;
      @(negedge clk);
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      bus.meas_valid = ($urandom_range(0, 3) == 0);
      bus.meas_bcd   = 16'($urandom) & mask;
      bus.msg_valid  = ($urandom_range(0, 7) == 0);
      bus.msg_bcd    = 16'($urandom);
      rst            = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    rst = 1'b0; bus.meas_valid = 0; bus.msg_valid = 0;
    repeat (2 * FRAME) @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
